// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end: FSM state encoding,
// opcode values, result-flag bit positions and the operand word width.
package calc_pkg;

    localparam int WORD_W = 16;

    // Encodings are what the board LEDs display.
    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        LOAD_OP  = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RDY = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int FLG_UNDERFLOW = 0;
    localparam int FLG_OVERFLOW  = 1;
    localparam int FLG_INEXACT   = 2;
    localparam int FLG_EXCEPTION = 3;
    localparam int FLG_INVALID   = 4;

    // Flags reported when the core never answers: invalid and exception.
    localparam logic [4:0] TIMEOUT_FLAGS = 5'b11000;

endpackage

// File: rtl/calc_button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and a one-cycle
// press pulse on each debounced rising edge of the button level.
module calc_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic [1:0]       fill;
    logic             armed;

    // armed stays low until the button has been seen released after reset, so a
    // button held through reset cannot generate a press when it settles.
    // NOTE: every register here is state, so it is written with <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            cnt       <= '0;
            stable    <= 1'b0;
            fill      <= 2'b00;
            armed     <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            sync_q1   <= btn_raw;
            sync_q2   <= sync_q1;
            fill      <= {fill[0], 1'b1};
            btn_press <= 1'b0;
            if (fill[1] && !sync_q2) begin
                armed <= 1'b1;
            end
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                stable    <= sync_q2;
                btn_press <= sync_q2 & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_level = stable;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Operand-entry sequencer in front of the calculator core: A, B, opcode, start,
// wait for ready, latch result. Optional WAIT_RDY timeout via SEQ_TIMEOUT_EN.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WORD_W-1:0] switches,
    input  logic              calc_ready,
    input  logic [WORD_W-1:0] calc_sum,
    input  logic              calc_sign,
    input  logic [4:0]        calc_flags,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    output logic [1:0]        opcode,
    output logic              calc_start,
    output logic [WORD_W-1:0] result,
    output logic              result_sign,
    output logic [4:0]        result_flags,
    output logic [2:0]        state_led,
    output logic              timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t state;
    logic       btn_level;
    logic       btn_press;
    logic       press;
    logic       tmo_expired;

    calc_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (enable),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    // The pulse only fires on a rising level; qualifying keeps the two coherent.
    assign press = btn_press & btn_level;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (state == WAIT_RDY && !calc_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_LAST) begin
                timeout <= 1'b1;
            end
        end
    end

    assign tmo_expired = (tmo_cnt == TMO_LAST);
`else
    assign timeout     = 1'b0;
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD_A;
            op_a         <= '0;
            op_b         <= '0;
            opcode       <= OP_ADD;
            result       <= '0;
            result_sign  <= 1'b0;
            result_flags <= '0;
        end else begin
            case (state)
                LOAD_A: if (press) begin
                    op_a  <= switches;
                    state <= LOAD_B;
                end
                LOAD_B: if (press) begin
                    op_b  <= switches;
                    state <= LOAD_OP;
                end
                LOAD_OP: if (press) begin
                    opcode <= switches[1:0];
                    state  <= ISSUE;
                end
                ISSUE: state <= WAIT_RDY;
                // A ready in the terminal-count cycle takes priority over the timeout.
                WAIT_RDY: if (calc_ready) begin
                    result       <= calc_sum;
                    result_sign  <= calc_sign;
                    result_flags <= calc_flags;
                    state        <= DONE;
                end else if (tmo_expired) begin
                    result       <= '0;
                    result_sign  <= 1'b0;
                    result_flags <= TIMEOUT_FLAGS;
                    state        <= DONE;
                end
                DONE: if (press) begin
                    state <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign calc_start = (state == ISSUE);
    assign state_led  = state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer with a scoreboard of expected
// results; DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_calc_operand_sequencer;

    localparam int DEB = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst, enable, calc_ready, calc_sign;
    logic [15:0] switches, calc_sum;
    logic [4:0]  calc_flags;
    logic [15:0] op_a, op_b, result;
    logic [1:0]  opcode;
    logic        calc_start, result_sign, timeout;
    logic [4:0]  result_flags;
    logic [2:0]  state_led;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] res;
        logic        sign;
        logic [4:0]  flags;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    calc_operand_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .switches    (switches),
        .calc_ready  (calc_ready),
        .calc_sum    (calc_sum),
        .calc_sign   (calc_sign),
        .calc_flags  (calc_flags),
        .op_a        (op_a),
        .op_b        (op_b),
        .opcode      (opcode),
        .calc_start  (calc_start),
        .result      (result),
        .result_sign (result_sign),
        .result_flags(result_flags),
        .state_led   (state_led),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst        = 1'b1;
        enable     = 1'b0;
        switches   = 16'h0000;
        calc_ready = 1'b0;
        calc_sum   = 16'h0000;
        calc_sign  = 1'b0;
        calc_flags = 5'b00000;
        tick;
        tick;
        rst = 1'b0;
        repeat (5) tick;
    endtask

    // Debounced press with switches presented, then a full release.
    task automatic press_enter(input logic [15:0] sw);
        bit seen = 0;
        switches = sw;
        enable   = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick;
            if (dut.u_btn.btn_press === 1'b1) seen = 1;
        end
        enable = 1'b0;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL press_enter_%h: got no press expected press within 20 cycles", sw);
        end
        repeat (8) tick;
    endtask

    // Opcode press; returns while the DUT sits in ISSUE.
    task automatic issue(input logic [15:0] sw);
        bit seen = 0;
        switches = sw;
        enable   = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick;
            if (calc_start === 1'b1) seen = 1;
        end
        enable = 1'b0;
        vectors++;
        if (!seen || state_led !== 3'd3) begin
            miscompares++;
            $display("FAIL issue_start: got start=%b state=%0d expected start=1 state=3", calc_start, state_led);
        end
    endtask

    // Core model: answer two cycles into WAIT_RDY, then compare at DONE.
    task automatic respond(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           input logic [15:0] sum, input logic sign, input logic [4:0] flags);
        tick;
        vectors++;
        if (calc_start !== 1'b0 || state_led !== 3'd4) begin
            miscompares++;
            $display("FAIL start_one_cycle: got start=%b state=%0d expected start=0 state=4", calc_start, state_led);
        end
        tick;
        sb.push_back('{a: a, b: b, op: op, res: sum, sign: sign, flags: flags, tmo: 1'b0});
        calc_ready = 1'b1;
        calc_sum   = sum;
        calc_sign  = sign;
        calc_flags = flags;
        tick;
        calc_ready = 1'b0;
        calc_sum   = 16'h0000;
        calc_sign  = 1'b0;
        calc_flags = 5'b00000;
        wait_done();
    endtask

    task automatic wait_done;
        exp_t e;
        bit   done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (state_led === 3'd5) done = 1;
            else tick;
        end
        vectors++;
        if (!done || sb.size() == 0) begin
            miscompares++;
            $display("FAIL reach_done: got state=%0d queue=%0d expected state=5 with pending entry", state_led, sb.size());
            return;
        end
        e = sb.pop_front();
        vectors++;
        if ({op_a, op_b, opcode} !== {e.a, e.b, e.op}) begin
            miscompares++;
            $display("FAIL operands: got a=%h b=%h op=%b expected a=%h b=%h op=%b", op_a, op_b, opcode, e.a, e.b, e.op);
        end
        vectors++;
        if ({result, result_sign, result_flags, timeout} !== {e.res, e.sign, e.flags, e.tmo}) begin
            miscompares++;
            $display("FAIL result: got %h/%b/%b/%b expected %h/%b/%b/%b",
                     result, result_sign, result_flags, timeout, e.res, e.sign, e.flags, e.tmo);
        end
    endtask

    task automatic test_reset;
        int presses = 0;
        rst        = 1'b1;
        enable     = 1'b1;
        switches   = 16'hFFFF;
        calc_ready = 1'b0;
        calc_sum   = 16'h0000;
        calc_sign  = 1'b0;
        calc_flags = 5'b00000;
        tick;
        tick;
        vectors++;
        if ({op_a, op_b, opcode, calc_start, result, result_sign, result_flags, state_led, timeout} !== 62'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%b st=%0d res=%h expected all zero", op_a, op_b, opcode, state_led, result);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (dut.u_btn.btn_press === 1'b1) presses++;
        end
        vectors++;
        if (presses != 0 || state_led !== 3'd0) begin
            miscompares++;
            $display("FAIL held_through_reset: got presses=%0d state=%0d expected 0 and 0", presses, state_led);
        end
        enable = 1'b0;
        repeat (10) tick;
    endtask

    task automatic test_press_latency;
        int presses = 0;
        int at      = -1;
        apply_reset();
        switches = 16'h00A5;
        enable   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (dut.u_btn.btn_press === 1'b1) begin
                presses++;
                at = k;
            end
        end
        vectors++;
        if (presses != 1 || at != DEB + 2) begin
            miscompares++;
            $display("FAIL press_latency: got presses=%0d at=%0d expected 1 at %0d", presses, at, DEB + 2);
        end
        vectors++;
        if (state_led !== 3'd1 || op_a !== 16'h00A5) begin
            miscompares++;
            $display("FAIL load_a: got state=%0d op_a=%h expected 1 and 00a5", state_led, op_a);
        end
        enable  = 1'b0;
        presses = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (dut.u_btn.btn_press === 1'b1) presses++;
        end
        vectors++;
        if (presses != 0 || state_led !== 3'd1) begin
            miscompares++;
            $display("FAIL release_no_press: got presses=%0d state=%0d expected 0 and 1", presses, state_led);
        end
    endtask

    task automatic test_bounce;
        logic [3:0] pattern = 4'b0101;
        int presses = 0;
        int rel     = 0;
        apply_reset();
        switches = 16'h1234;
        for (int i = 3; i >= 0; i--) begin
            enable = pattern[i] ^ 1'b1;
            tick;
            if (dut.u_btn.btn_press === 1'b1) presses++;
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (dut.u_btn.btn_press === 1'b1) presses++;
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (dut.u_btn.btn_press === 1'b1) rel++;
        end
        vectors++;
        if (presses != 1 || rel != 0) begin
            miscompares++;
            $display("FAIL bounce: got presses=%0d release_presses=%0d expected 1 and 0", presses, rel);
        end
        vectors++;
        if (state_led !== 3'd1 || op_a !== 16'h1234) begin
            miscompares++;
            $display("FAIL bounce_state: got state=%0d op_a=%h expected 1 and 1234", state_led, op_a);
        end
    endtask

    task automatic test_full_sequence;
        apply_reset();
        press_enter(16'h3C00);
        press_enter(16'h4000);
        issue(16'h0000);
        respond(16'h3C00, 16'h4000, 2'b00, 16'h4200, 1'b0, 5'b00000);
        repeat (10) tick;
        vectors++;
        if (state_led !== 3'd5 || result !== 16'h4200) begin
            miscompares++;
            $display("FAIL done_hold: got state=%0d result=%h expected 5 and 4200", state_led, result);
        end
    endtask

    task automatic test_ignored_inputs;
        apply_reset();
        press_enter(16'h1111);
        calc_ready = 1'b1;
        calc_sum   = 16'hBEEF;
        calc_flags = 5'b11111;
        tick;
        calc_ready = 1'b0;
        calc_sum   = 16'h0000;
        calc_flags = 5'b00000;
        tick;
        vectors++;
        if (state_led !== 3'd1 || result !== 16'h0000 || result_flags !== 5'b00000) begin
            miscompares++;
            $display("FAIL ready_in_load_b: got state=%0d result=%h expected 1 and 0000", state_led, result);
        end
        press_enter(16'h2222);
        issue(16'h0002);
        repeat (8) tick;
        enable = 1'b1;
        repeat (10) tick;
        enable = 1'b0;
        repeat (10) tick;
        vectors++;
        if (state_led !== 3'd4 || op_a !== 16'h1111 || op_b !== 16'h2222 || opcode !== 2'b10) begin
            miscompares++;
            $display("FAIL press_in_wait: got state=%0d a=%h b=%h op=%b expected 4 1111 2222 10", state_led, op_a, op_b, opcode);
        end
        respond(16'h1111, 16'h2222, 2'b10, 16'h5555, 1'b1, 5'b00100);
        press_enter(16'h9999);
        vectors++;
        if (state_led !== 3'd0 || op_a !== 16'h1111 || result !== 16'h5555) begin
            miscompares++;
            $display("FAIL done_to_load_a: got state=%0d a=%h res=%h expected 0 1111 5555", state_led, op_a, result);
        end
    endtask

    // Continues from LOAD_A with non-zero registers left by the previous test.
    task automatic test_reset_mid_wait;
        press_enter(16'h7777);
        press_enter(16'h8888);
        issue(16'h0003);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if ({op_a, op_b, opcode, calc_start, result, result_sign, result_flags, state_led, timeout} !== 62'd0) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got a=%h b=%h op=%b st=%0d res=%h expected all zero", op_a, op_b, opcode, state_led, result);
        end
        calc_ready = 1'b1;
        calc_sum   = 16'hABCD;
        tick;
        calc_ready = 1'b0;
        calc_sum   = 16'h0000;
        tick;
        vectors++;
        if (result !== 16'h0000 || state_led !== 3'd0) begin
            miscompares++;
            $display("FAIL ready_after_reset: got result=%h state=%0d expected 0000 and 0", result, state_led);
        end
    endtask

    task automatic test_timeout;
        apply_reset();
        press_enter(16'h0101);
        press_enter(16'h0202);
        issue(16'h0001);
`ifdef SEQ_TIMEOUT_EN
        begin
            int waits = 0;
            bit left  = 0;
            sb.push_back('{a: 16'h0101, b: 16'h0202, op: 2'b01, res: 16'h0000, sign: 1'b0, flags: 5'b11000, tmo: 1'b1});
            for (int i = 0; i < 40 && !left; i++) begin
                tick;
                if (state_led === 3'd4) waits++;
                else left = 1;
            end
            vectors++;
            if (waits != TMO) begin
                miscompares++;
                $display("FAIL timeout_wait_cycles: got %0d expected %0d", waits, TMO);
            end
            wait_done();
            press_enter(16'h0000);
            press_enter(16'h0303);
            press_enter(16'h0404);
            issue(16'h0000);
            tick;
            vectors++;
            if (timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_clear: got %b expected 0", timeout);
            end
            respond(16'h0303, 16'h0404, 2'b00, 16'h0707, 1'b0, 5'b00000);
        end
`else
        repeat (40) tick;
        vectors++;
        if (state_led !== 3'd4 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_forever: got state=%0d timeout=%b expected 4 and 0", state_led, timeout);
        end
        respond(16'h0101, 16'h0202, 2'b01, 16'h0606, 1'b0, 5'b00010);
`endif
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_bounce();
        test_full_sequence();
        test_ignored_inputs();
        test_reset_mid_wait();
        test_timeout();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_operand_sequencer.md
Name: calc_operand_sequencer

Overview:
- Front-end stage directly upstream of the 16-bit calculator core.
- Turns the board's raw enable push-button and 16 slide switches into a controlled operand-entry sequence: operand A, operand B, opcode.
- Issues a one-cycle start to the core, waits for its ready, then latches the result and exception flags for the display stage.
- All control is a single FSM plus one button-conditioning sub-block.

Parameters:
- DEBOUNCE_CYCLES, 500000, clocks the synchronized button level must stay constant before it is accepted (min 2).
- TIMEOUT_CYCLES, 1024, maximum clocks WAIT_RDY waits for calc_ready (only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  raw, asynchronous, bouncing push-button; active high
- switches  in  16  slide switches, sampled only on an accepted press
- calc_ready  in  1  core result valid; level or pulse
- calc_sum  in  16  core result word
- calc_sign  in  1  core result sign
- calc_flags  in  5  {invalid, exception, inexact, overflow, underflow}
- op_a  out  16  latched operand A
- op_b  out  16  latched operand B
- opcode  out  2  00 add, 01 sub, 10 mul, 11 div
- calc_start  out  1  one-cycle start pulse to core
- result  out  16  latched calc_sum
- result_sign  out  1  latched calc_sign
- result_flags  out  5  latched calc_flags
- state_led  out  3  current FSM state encoding, for board LEDs
- timeout  out  1  set when the core failed to respond; cleared on the next issue

Behaviour:
- Reset:
  - Applies at the rising edge where rst=1 and overrides everything, including mid-WAIT_RDY.
  - All outputs go to 0; FSM goes to LOAD_A; conditioner sync flops, counter and stable level are cleared.
  - A button already held through reset produces no press until it is released and pressed again.
- Button conditioning:
  - 2-flop synchronizer, then debounce counter.
  - The counter clears whenever the synchronized level equals the stable level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level flips.
  - press = one-cycle pulse on a stable 0->1 transition.
  - Clean input latency: press is high in cycle DEBOUNCE_CYCLES+2 after the first edge that samples enable=1.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press. Release produces no press.
- FSM states (state_led encodes 0..5):
  - LOAD_A(0): on press, op_a<=switches; go to LOAD_B.
  - LOAD_B(1): on press, op_b<=switches; go to LOAD_OP.
  - LOAD_OP(2): on press, opcode<=switches[1:0]; go to ISSUE.
  - ISSUE(3): calc_start=1 for exactly this one cycle; timeout<=0; go to WAIT_RDY.
  - WAIT_RDY(4):
    - On calc_ready=1: result, result_sign and result_flags latch the same-cycle calc_* values; go to DONE.
    - Presses are ignored.
  - DONE(5): outputs hold. On press, go to LOAD_A. Operand registers keep their old values until overwritten.
- calc_start is never asserted outside ISSUE, so back-to-back starts are impossible.
- calc_ready seen outside WAIT_RDY is ignored. It may already be high on entry to WAIT_RDY; the result is then captured on the first WAIT_RDY cycle.
- Operands and opcode are held stable from ISSUE through DONE.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears in ISSUE and increments each WAIT_RDY cycle.
  - If it reaches TIMEOUT_CYCLES with no calc_ready: timeout<=1, result<=16'h0000, result_sign<=0, result_flags<=5'b11000 (invalid and exception set); go to DONE.
  - If calc_ready and the terminal count occur in the same cycle, ready wins and timeout stays 0.
- Not defined: no counter; WAIT_RDY waits indefinitely; timeout is tied to 0.

Decomposition:
- Package calc_pkg:
  - FSM state enum, with encodings matching state_led.
  - Opcode localparams: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - Flag bit indices: FLG_UNDERFLOW=0 .. FLG_INVALID=4.
  - Constant WORD_W=16.
- Sub-module calc_button_conditioner (parameter DEBOUNCE_CYCLES):
  - Inputs clk, rst, btn_raw.
  - Outputs btn_level, btn_press.
  - Reused for any future buttons.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16):
- Reset, then enable held high 10 cycles -> exactly one press; it appears 6 cycles after the first edge sampling enable=1; state LOAD_A->LOAD_B.
- Enable bounce pattern 1,0,1,0 one cycle each, then steady -> exactly one press; no press on release.
- Full sequence:
  - Inputs: presses with switches 16'h3C00, then 16'h4000, then 16'h0000; core model returns calc_sum=16'h4200, flags=0 three cycles after start.
  - Required: op_a=3C00, op_b=4000, opcode=00; calc_start exactly 1 cycle; result=4200; state DONE.
- Press during WAIT_RDY, plus calc_ready pulsed while in LOAD_B -> both ignored; operands and result unchanged.
- rst asserted mid-WAIT_RDY -> next cycle all outputs 0, state LOAD_A; a later calc_ready is not captured.
- SEQ_TIMEOUT_EN defined, core never ready -> DONE after 16 WAIT_RDY cycles; timeout=1, result_flags=5'b11000; next issue clears timeout.
